// File: rtl/wb_burst_pkg.sv
// Shared FSM state encoding and Wishbone cycle-type constants for the burst master.
package wb_burst_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WR    = 2'd1,
        S_RD    = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_burst_rd_fifo.sv
// Read-data buffer: DEPTH entries including a registered head word.
// Latency: a push is visible on vld_o the cycle after it is written.
// Backpressure: the producer must respect count_o; pop happens when vld_o && pop_rdy_i.
module wb_burst_rd_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [DW-1:0]            din_i,
    input  logic                     pop_rdy_i,
    output logic                     vld_o,
    output logic [DW-1:0]            dout_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   mcnt_q;
    logic          vld_q;
    logic [DW-1:0] dout_q;
    logic          head_free, refill, push_mem;

    // The head register refills from the backlog first, or directly from push when empty.
    assign head_free = !vld_q || pop_rdy_i;
    assign refill    = head_free && (mcnt_q != '0);
    assign push_mem  = push_i && !(head_free && (mcnt_q == '0));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q  <= 1'b0;
            dout_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            mcnt_q <= '0;
        end else if (flush_i) begin
            vld_q  <= 1'b0;
            wptr_q <= '0;
            rptr_q <= '0;
            mcnt_q <= '0;
        end else begin
            if (head_free) begin
                if (refill) begin
                    dout_q <= mem_q[rptr_q];
                    rptr_q <= rptr_q + 1'b1;
                    vld_q  <= 1'b1;
                end else if (push_i) begin
                    dout_q <= din_i;
                    vld_q  <= 1'b1;
                end else begin
                    vld_q  <= 1'b0;
                end
            end
            if (push_mem) wptr_q <= wptr_q + 1'b1;
            mcnt_q <= mcnt_q + {{PW{1'b0}}, push_mem} - {{PW{1'b0}}, refill};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_mem && !flush_i) mem_q[wptr_q] <= din_i;
    end

    assign vld_o   = vld_q;
    assign dout_o  = dout_q;
    assign count_o = mcnt_q + {{PW{1'b0}}, vld_q};

endmodule

// File: rtl/wb_burst_master.sv
// Command-to-Wishbone incrementing burst master; optional ack watchdog via WB_BURST_MASTER_TIMEOUT_EN.
// Latency: bus cycle starts the cycle after command accept; read data appears one cycle after its ack.
// Backpressure: write beats stall on wd_valid, read beats stall while the read buffer is full.
module wb_burst_master import wb_burst_pkg::*; #(
    parameter int dw            = 32,
    parameter int aw            = 32,
    parameter int bl            = 9,
    parameter int RD_FIFO_DEPTH = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [aw-1:0]     cmd_addr,
    input  logic [bl-1:0]     cmd_len,
    input  logic              cmd_wr,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [dw-1:0]     wd_data,
    input  logic [dw/8-1:0]   wd_sel,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [dw-1:0]     rd_data,
    output logic              done,
    output logic              err,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [aw-1:0]     wb_adr_o,
    output logic [dw-1:0]     wb_dat_o,
    output logic [dw/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    output logic [1:0]        wb_bte_o,
    input  logic [dw-1:0]     wb_dat_i,
    input  logic              wb_ack_i
);
    localparam int SW  = dw / 8;
    localparam int FCW = $clog2(RD_FIFO_DEPTH) + 1;

    state_t          state_q;
    logic            cyc_q, we_q, done_q, err_q;
    logic [aw-1:0]   adr_q;
    logic [bl-1:0]   rem_q;
    logic [FCW-1:0]  fifo_cnt;
    logic            stb, beat, push, last, to_hit;

    always_comb begin
        stb = 1'b0;
        if (cyc_q) begin
            if (state_q == S_WR)      stb = wd_valid;
            else if (state_q == S_RD) stb = (fifo_cnt < FCW'(RD_FIFO_DEPTH));
        end
    end

    assign beat = stb && wb_ack_i;
    assign push = beat && (state_q == S_RD);
    assign last = (rem_q == bl'(1));

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_q;

    // Counts consecutive strobed cycles without an ack; gaps with stb low hold the count.
    assign to_hit = stb && !wb_ack_i && (to_q == TW'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)               to_q <= '0;
        else if (beat || !cyc_q)    to_q <= '0;
        else if (stb)               to_q <= to_q + 1'b1;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            adr_q   <= '0;
            rem_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        err_q <= 1'b0;
                        adr_q <= cmd_addr & ~aw'(SW - 1);
                        rem_q <= cmd_len;
                        if (cmd_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            cyc_q   <= 1'b1;
                            we_q    <= cmd_wr;
                            state_q <= cmd_wr ? S_WR : S_RD;
                        end
                    end
                end
                S_WR, S_RD: begin
                    if (beat) begin
                        adr_q <= adr_q + aw'(SW);
                        rem_q <= rem_q - bl'(1);
                        if (last) begin
                            cyc_q <= 1'b0;
                            we_q  <= 1'b0;
                            if (state_q == S_WR) begin
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end else begin
                                state_q <= S_FLUSH;
                            end
                        end
                    end else if (to_hit) begin
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (fifo_cnt == '0) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    wb_burst_rd_fifo #(
        .DW    (dw),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_rd_fifo (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .flush_i   (to_hit),
        .push_i    (push),
        .din_i     (wb_dat_i),
        .pop_rdy_i (rd_ready),
        .vld_o     (rd_valid),
        .dout_o    (rd_data),
        .count_o   (fifo_cnt)
    );

    assign cmd_ready = (state_q == S_IDLE) && !wb_rst_i;
    assign wd_ready  = beat && (state_q == S_WR);
    assign done      = done_q;
`ifdef WB_BURST_MASTER_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = wd_data;
    assign wb_sel_o  = wd_sel;
    assign wb_cti_o  = cyc_q ? (last ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;
    assign wb_bte_o  = 2'b00;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master with a configurable wait-state Wishbone slave model.
module tb_wb_burst_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [8:0]  cmd_len = '0;
    logic        wd_valid = 1'b0, wd_ready;
    logic [31:0] wd_data;
    logic [3:0]  wd_sel;
    logic        rd_valid, rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        done, err;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_ack_i;

    int checks = 0;
    int failures = 0;

    int slv_wait = 0;
    bit slv_never = 1'b0;
    int slv_cnt = 0;
    int cycle = 0, done_cnt = 0, done_cyc = 0, acc_cyc = 0;
    logic [31:0] wd_idx = '0;

    logic [31:0] ack_adr[$];
    logic [2:0]  ack_cti[$];
    logic [31:0] ack_dat[$];
    logic [3:0]  ack_sel[$];
    logic        ack_we[$];
    int          ack_cyc[$];
    logic [31:0] rd_log[$];
    int          pop_cyc[$];

    wb_burst_master #(
        .dw(32), .aw(32), .bl(9), .RD_FIFO_DEPTH(4), .TIMEOUT(16)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_wr(cmd_wr),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_sel(wd_sel),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .err(err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;

    assign wb_ack_i = wb_stb_o && !slv_never && (slv_cnt >= slv_wait);
    assign wb_dat_i = 32'hA5A5_0000 ^ wb_adr_o;
    assign wd_data  = 32'hD000_0000 + wd_idx;
    assign wd_sel   = wd_idx[0] ? 4'h3 : 4'hF;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cycle;
        end
        if (cmd_valid && cmd_ready) acc_cyc <= cycle;
        if (wb_stb_o && wb_ack_i) begin
            ack_adr.push_back(wb_adr_o);
            ack_cti.push_back(wb_cti_o);
            ack_dat.push_back(wb_dat_o);
            ack_sel.push_back(wb_sel_o);
            ack_we.push_back(wb_we_o);
            ack_cyc.push_back(cycle);
        end
        if (rd_valid && rd_ready) begin
            rd_log.push_back(rd_data);
            pop_cyc.push_back(cycle);
        end
        if (wd_ready) wd_idx <= wd_idx + 32'd1;
        if (wb_stb_o && !wb_ack_i) slv_cnt <= slv_cnt + 1;
        else slv_cnt <= 0;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic clear_logs();
        ack_adr.delete(); ack_cti.delete(); ack_dat.delete(); ack_sel.delete();
        ack_we.delete(); ack_cyc.delete(); rd_log.delete(); pop_cyc.delete();
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [8:0] l, input logic w);
        int n = 0;
        @(negedge clk);
        cmd_addr = a; cmd_len = l; cmd_wr = w; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL cmd_accept: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int d0, input int lim, input string nm);
        int n = 0;
        while (done_cnt == d0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            failures++;
            $display("FAIL %s_done_timeout: done_cnt=%0d after %0d cycles, required >%0d", nm, done_cnt, lim, d0);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, done, err, rd_valid, wd_ready, cmd_ready} !== 8'b0) begin
            failures++;
            $display("FAIL reset_ctrl: cyc,stb,we,done,err,rd_valid,wd_ready,cmd_ready=%b required 00000000",
                     {wb_cyc_o, wb_stb_o, wb_we_o, done, err, rd_valid, wd_ready, cmd_ready});
        end
        checks++;
        if (wb_adr_o !== 32'h0 || wb_cti_o !== 3'b000 || wb_bte_o !== 2'b00) begin
            failures++;
            $display("FAIL reset_bus: adr=%h cti=%b bte=%b required 0/000/00", wb_adr_o, wb_cti_o, wb_bte_o);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_write_burst();
        int d0 = done_cnt;
        logic [31:0] base = wd_idx;
        logic [31:0] e;
        clear_logs();
        slv_wait = 0;
        wd_valid = 1'b1;
        send_cmd(32'h0000_0100, 9'd4, 1'b1);
        checks++;
        if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || wb_we_o !== 1'b1 || wb_adr_o !== 32'h100) begin
            failures++;
            $display("FAIL wr_first_beat: cyc=%b stb=%b we=%b adr=%h required 1/1/1/00000100",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o);
        end
        wait_done(d0, 30, "wr");
        wd_valid = 1'b0;
        checks++;
        if (ack_adr.size() != 4) begin
            failures++;
            $display("FAIL wr_ack_count: got %0d required 4", ack_adr.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                e = base + 32'(k);
                checks++;
                if (ack_adr[k] !== 32'h100 + 32'(4 * k) || ack_cti[k] !== (k == 3 ? 3'b111 : 3'b010)
                    || ack_dat[k] !== 32'hD000_0000 + e || ack_sel[k] !== (e[0] ? 4'h3 : 4'hF)
                    || ack_we[k] !== 1'b1) begin
                    failures++;
                    $display("FAIL wr_beat%0d: adr=%h cti=%b dat=%h sel=%h we=%b required %h/%b/%h/%h/1",
                             k, ack_adr[k], ack_cti[k], ack_dat[k], ack_sel[k], ack_we[k],
                             32'h100 + 32'(4 * k), (k == 3 ? 3'b111 : 3'b010), 32'hD000_0000 + e,
                             (e[0] ? 4'h3 : 4'hF));
                end
            end
            checks++;
            if (ack_cyc[0] != acc_cyc + 1 || ack_cyc[3] != acc_cyc + 4) begin
                failures++;
                $display("FAIL wr_zero_wait_timing: acks at +%0d..+%0d required +1..+4",
                         ack_cyc[0] - acc_cyc, ack_cyc[3] - acc_cyc);
            end
            checks++;
            if (done_cyc != ack_cyc[3] + 1 || done_cnt != d0 + 1) begin
                failures++;
                $display("FAIL wr_done_timing: done at +%0d after last ack (count %0d) required +1 (count %0d)",
                         done_cyc - ack_cyc[3], done_cnt - d0, 1);
            end
        end
        @(negedge clk);
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_cti_o !== 3'b000 || wb_adr_o !== 32'h110) begin
            failures++;
            $display("FAIL wr_idle_after: cyc=%b cti=%b adr=%h required 0/000/00000110", wb_cyc_o, wb_cti_o, wb_adr_o);
        end
    endtask

    task automatic test_read_waits();
        int d0 = done_cnt;
        clear_logs();
        slv_wait = 2;
        rd_ready = 1'b1;
        send_cmd(32'h0000_0203, 9'd3, 1'b0);
        wait_done(d0, 60, "rd_wait");
        checks++;
        if (rd_log.size() != 3 || ack_adr.size() != 3) begin
            failures++;
            $display("FAIL rd_wait_count: words=%0d acks=%0d required 3/3", rd_log.size(), ack_adr.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rd_log[k] !== (32'hA5A5_0000 ^ (32'h200 + 32'(4 * k)))) begin
                    failures++;
                    $display("FAIL rd_wait_word%0d: got %h required %h", k, rd_log[k], 32'hA5A5_0000 ^ (32'h200 + 32'(4 * k)));
                end
            end
            checks++;
            if (ack_cyc[0] != acc_cyc + 3 || ack_cyc[1] != acc_cyc + 6) begin
                failures++;
                $display("FAIL rd_wait_states: acks at +%0d,+%0d required +3,+6", ack_cyc[0] - acc_cyc, ack_cyc[1] - acc_cyc);
            end
            checks++;
            if (pop_cyc[0] != ack_cyc[0] + 1) begin
                failures++;
                $display("FAIL rd_valid_latency: pop at +%0d after ack required +1", pop_cyc[0] - ack_cyc[0]);
            end
            checks++;
            if (done_cyc <= pop_cyc[2] || done_cnt != d0 + 1) begin
                failures++;
                $display("FAIL rd_wait_done: done at %0d last pop at %0d count %0d required after pop, count 1",
                         done_cyc, pop_cyc[2], done_cnt - d0);
            end
        end
        slv_wait = 0;
    endtask

    task automatic test_read_backpressure();
        int d0 = done_cnt;
        clear_logs();
        rd_ready = 1'b0;
        send_cmd(32'h0000_0300, 9'd8, 1'b0);
        repeat (20) @(negedge clk);
        checks++;
        if (ack_adr.size() != 4 || wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b1) begin
            failures++;
            $display("FAIL rd_bp_stall: acks=%0d stb=%b cyc=%b required 4/0/1", ack_adr.size(), wb_stb_o, wb_cyc_o);
        end
        rd_ready = 1'b1;
        wait_done(d0, 80, "rd_bp");
        checks++;
        if (rd_log.size() != 8 || ack_adr.size() != 8) begin
            failures++;
            $display("FAIL rd_bp_count: words=%0d acks=%0d required 8/8", rd_log.size(), ack_adr.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (rd_log[k] !== (32'hA5A5_0000 ^ (32'h300 + 32'(4 * k)))) begin
                    failures++;
                    $display("FAIL rd_bp_word%0d: got %h required %h", k, rd_log[k], 32'hA5A5_0000 ^ (32'h300 + 32'(4 * k)));
                end
            end
            checks++;
            if (ack_cti[7] !== 3'b111 || ack_cti[6] !== 3'b010) begin
                failures++;
                $display("FAIL rd_bp_cti: beat6=%b beat7=%b required 010/111", ack_cti[6], ack_cti[7]);
            end
        end
    endtask

    task automatic test_zero_len();
        int d0 = done_cnt;
        int cyc_seen = 0;
        clear_logs();
        send_cmd(32'h0000_0800, 9'd0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (wb_cyc_o !== 1'b0) cyc_seen++;
            @(negedge clk);
        end
        checks++;
        if (cyc_seen != 0 || ack_adr.size() != 0) begin
            failures++;
            $display("FAIL zero_len_bus: cyc high %0d cycles, acks %0d required 0/0", cyc_seen, ack_adr.size());
        end
        checks++;
        if (done_cnt != d0 + 1 || done_cyc != acc_cyc + 1) begin
            failures++;
            $display("FAIL zero_len_done: count %0d at +%0d required 1 at +1", done_cnt - d0, done_cyc - acc_cyc);
        end
    endtask

    task automatic test_write_gapped();
        int d0 = done_cnt;
        int n = 0;
        int gaps = 0;
        clear_logs();
        wd_valid = 1'b0;
        send_cmd(32'h0000_0400, 9'd3, 1'b1);
        while (done_cnt == d0 && n < 40) begin
            wd_valid = ~wd_valid;
            #1;
            if (wb_cyc_o) begin
                if (!wb_stb_o) gaps++;
                checks++;
                if (wb_stb_o !== wd_valid || wb_adr_o !== 32'h400 + 32'(4 * ack_adr.size())) begin
                    failures++;
                    $display("FAIL gap_follow: stb=%b wd_valid=%b adr=%h required stb=%b adr=%h",
                             wb_stb_o, wd_valid, wb_adr_o, wd_valid, 32'h400 + 32'(4 * ack_adr.size()));
                end
            end else if (!done && done_cnt == d0) begin
                checks++;
                failures++;
                $display("FAIL gap_cyc_drop: cyc=%b before done required 1", wb_cyc_o);
            end
            @(negedge clk);
            n++;
        end
        wd_valid = 1'b0;
        checks++;
        if (done_cnt != d0 + 1 || ack_adr.size() != 3 || gaps < 2) begin
            failures++;
            $display("FAIL gap_summary: done=%0d acks=%0d gaps=%0d required 1/3/>=2", done_cnt - d0, ack_adr.size(), gaps);
        end
    endtask

    task automatic test_reset_mid_read();
        int d0 = done_cnt;
        int n = 0;
        clear_logs();
        rd_ready = 1'b1;
        send_cmd(32'h0000_0500, 9'd6, 1'b0);
        while (ack_adr.size() < 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || rd_valid !== 1'b0 || wb_we_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_async: cyc=%b stb=%b rd_valid=%b we=%b required 0/0/0/0", wb_cyc_o, wb_stb_o, rd_valid, wb_we_o);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != d0 || ack_adr.size() != 2 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_after: done=%0d acks=%0d rd_valid=%b required 0/2/0", done_cnt - d0, ack_adr.size(), rd_valid);
        end
        clear_logs();
        send_cmd(32'h0000_0600, 9'd2, 1'b0);
        wait_done(d0, 40, "rst_next");
        checks++;
        if (rd_log.size() != 2 || rd_log[0] !== (32'hA5A5_0000 ^ 32'h600) || rd_log[1] !== (32'hA5A5_0000 ^ 32'h604)) begin
            failures++;
            $display("FAIL rst_next_data: words=%0d first=%h required 2 words starting %h",
                     rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 32'h0, 32'hA5A5_0000 ^ 32'h600);
        end
    endtask

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int d0 = done_cnt;
        clear_logs();
        slv_never = 1'b1;
        send_cmd(32'h0000_0700, 9'd2, 1'b0);
        repeat (15) @(negedge clk);
        checks++;
        if (wb_cyc_o !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL to_before: cyc=%b err=%b at cycle 16 required 1/0", wb_cyc_o, err);
        end
        @(negedge clk);
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || err !== 1'b1 || done !== 1'b1) begin
            failures++;
            $display("FAIL to_abort: cyc=%b stb=%b err=%b done=%b required 0/0/1/1", wb_cyc_o, wb_stb_o, err, done);
        end
        slv_never = 1'b0;
        send_cmd(32'h0000_0000, 9'd0, 1'b0);
        checks++;
        if (err !== 1'b0 || done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL to_clear: err=%b done_cnt=%0d required 0/1", err, done_cnt - d0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_burst();
        test_read_waits();
        test_read_backpressure();
        test_zero_len();
        test_write_gapped();
        test_reset_mid_read();
`ifdef WB_BURST_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
